// File: rtl/rf_dump_uart.sv
// rf_dump_uart
//   Debug reader for the register file's query port. When a start request
//   arrives, it reads registers 0..31 in order. Each 32-bit word is sent on
//   a UART line as four 8N1 bytes, most-significant byte first.
//
// Ports:
//   clk      - sole clock, rising edge
//   rst      - synchronous active-high reset
//   start    - dump request, sampled only while idle
//   RFQUERY  - register index presented to the register file (registered)
//   RFOUT    - register file query data for RFQUERY
//   tx       - UART transmit line, idle high (registered)
//   busy     - high while a dump is in progress
//   done     - one-cycle pulse on the first idle cycle after register 31
module rf_dump_uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  RFQUERY,
  input  logic [31:0] RFOUT,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state_reg;
  logic [4:0]        idx_reg;
  logic [31:0]       shreg_reg;
  logic [1:0]        byte_cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic              tx_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              baud_end;
  logic [2:0]        bit_next;

  assign baud_end = (baud_reg == BAUD_LAST);
  assign bit_next = bit_cnt_reg + 3'd1;

  // tx is a register. Each transition also loads the line level for the
  // state being entered, so every bit holds for exactly CLKS_PER_BIT cycles.
  // The byte being sent is always shreg[31:24]. Index {2'b11, n} selects
  // bit 24+n of shreg.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      idx_reg      <= 5'd0;
      shreg_reg    <= 32'd0;
      byte_cnt_reg <= 2'd0;
      bit_cnt_reg  <= 3'd0;
      baud_reg     <= '0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
          if (start) begin
            idx_reg   <= 5'd0;
            busy_reg  <= 1'b1;
            state_reg <= S_LOAD;
          end
        end

        // Capture the word once. Writes to the register file after this
        // point do not change the bytes of this word.
        S_LOAD: begin
          shreg_reg    <= RFOUT;
          byte_cnt_reg <= 2'd0;
          baud_reg     <= '0;
          tx_reg       <= 1'b0;
          state_reg    <= S_START;
        end

        S_START: begin
          if (baud_end) begin
            baud_reg    <= '0;
            bit_cnt_reg <= 3'd0;
            tx_reg      <= shreg_reg[24];
            state_reg   <= S_DATA;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        S_DATA: begin
          if (baud_end) begin
            baud_reg <= '0;
            if (bit_cnt_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= S_STOP;
            end else begin
              bit_cnt_reg <= bit_next;
              tx_reg      <= shreg_reg[{2'b11, bit_next}];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        S_STOP: begin
          if (baud_end) begin
            baud_reg <= '0;
            if (byte_cnt_reg != 2'd3) begin
              // The next byte of the same word follows with no gap.
              shreg_reg    <= shreg_reg << 8;
              byte_cnt_reg <= byte_cnt_reg + 2'd1;
              tx_reg       <= 1'b0;
              state_reg    <= S_START;
            end else if (idx_reg != 5'd31) begin
              // The LOAD cycle adds one idle-high cycle between words.
              idx_reg   <= idx_reg + 5'd1;
              tx_reg    <= 1'b1;
              state_reg <= S_LOAD;
            end else begin
              tx_reg    <= 1'b1;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= S_IDLE;
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        default: begin
          tx_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign RFQUERY = idx_reg;
  assign tx      = tx_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule
